// File: rtl/sfft_readout_controller.sv
// ---------------------------------------------------------------------------
// sfft_readout_controller
//
// Arbitrates host access to one completed SFFT output frame. New frames are
// detected on the rising edge of sfft_output_valid; the host takes an
// exclusive lock through the control register. While the lock is held, the
// pipeline is told not to overwrite its output buffer. Bins are then served
// as 8-bit bytes with a fixed two-cycle read latency. The block also
// snapshots the frame counter at lock time, counts frames dropped while
// locked, and force-releases a lock that is held for too long.
//
// Ports:
//   clk, reset             system clock; asynchronous active-high reset
//   chipselect/write/read  8-bit memory-mapped slave strobes
//   address[15:0]          byte address
//   writedata[7:0]         write data (control register only)
//   readdata[7:0]          registered read data
//   readdatavalid          one-cycle pulse marking readdata valid
//   sfft_output_valid      pipeline level; rising edge = new frame
//   sfft_read_error        pipeline flag: output buffer disturbed
//   sfft_read_data[31:0]   BRAM data, valid one cycle after sfft_read_addr
//   sfft_read_addr         bin index presented to the BRAM
//   sfft_output_being_read high while the lock is held
//
// Register map (B = BINS*4):
//   A <  B    read bin A[AW+1:2], byte A[1:0] (little-endian); 0 unless locked
//   B..B+3    read ts_snap, little-endian
//   B+4       read status {4'b0, timeout, overrun, locked, state!=IDLE}
//   B+5       read drop_count
//   B         write control: bit0 lock/unlock, bit1 clear flags + drop_count
// ---------------------------------------------------------------------------
module sfft_readout_controller #(
   parameter  int BINS           = 256,
   parameter  int TIMEOUT_CYCLES = 1000000,
   localparam int AW             = $clog2(BINS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          chipselect,
   input  logic          write,
   input  logic          read,
   input  logic [15:0]   address,
   input  logic [7:0]    writedata,
   output logic [7:0]    readdata,
   output logic          readdatavalid,
   input  logic          sfft_output_valid,
   input  logic          sfft_read_error,
   input  logic [31:0]   sfft_read_data,
   output logic [AW-1:0] sfft_read_addr,
   output logic          sfft_output_being_read
);

   localparam int          BASE   = BINS * 4;
   localparam logic [15:0] BASE_A = 16'(BASE);
   localparam int          TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READY  = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t          state, state_d;
   logic            valid_q;
   logic [31:0]     frame_count;
   logic [31:0]     ts_snap, ts_d;
   logic [7:0]      drop_count, drop_d;
   logic            overrun_flag, overrun_d;
   logic            timeout_flag, timeout_d;
   logic            pending, pending_d;
   logic [TW-1:0]   tcnt, tcnt_d;
   logic            being_read_q;

   // Bus decode. A write in the same cycle as a read suppresses the read.
   logic            frame_edge;
   logic            rd_accept, wr_en, ctrl_wr;
   logic            lock_req, unlock_req, clr_req;
   logic            timeout_hit;
   logic            is_bin;
   logic [15:0]     ofs;
   logic [7:0]      status_byte;
   logic [7:0]      reg_byte;

   assign frame_edge  = sfft_output_valid & ~valid_q;
   assign rd_accept   = chipselect & read & ~write;
   assign wr_en       = chipselect & write;
   assign ctrl_wr     = wr_en & (address == BASE_A);
   assign lock_req    = ctrl_wr &  writedata[0];
   assign unlock_req  = ctrl_wr & ~writedata[0];
   assign clr_req     = ctrl_wr &  writedata[1];
   assign timeout_hit = (state == S_LOCKED) && (tcnt == TO_MAX);
   assign is_bin      = address < BASE_A;
   assign ofs         = address - BASE_A;

   // Upper control bits have no function.
   logic unused_wdata;
   assign unused_wdata = ^writedata[7:2];

   assign status_byte = {4'b0000, timeout_flag, overrun_flag,
                         state == S_LOCKED, state != S_IDLE};

   // -----------------------------------------------------------------------
   // FSM and flag next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d   = state;
      pending_d = pending;
      overrun_d = overrun_flag;
      timeout_d = timeout_flag;
      drop_d    = drop_count;
      tcnt_d    = tcnt;
      ts_d      = ts_snap;

      // Clear first so that a set event in the same cycle overrides it.
      if (clr_req) begin
         overrun_d = 1'b0;
         timeout_d = 1'b0;
         drop_d    = 8'd0;
      end

      unique case (state)
         S_IDLE: begin
            // A lock write here is ignored, even alongside a frame edge.
            if (frame_edge) state_d = S_READY;
         end
         S_READY: begin
            if (lock_req) begin
               state_d = S_LOCKED;
               ts_d    = frame_count;
               tcnt_d  = '0;
            end
         end
         S_LOCKED: begin
            if (!timeout_hit) tcnt_d = tcnt + TW'(1);
            if (frame_edge) begin
               pending_d = 1'b1;
               overrun_d = 1'b1;
               if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
            end
            if (sfft_read_error) overrun_d = 1'b1;
            if (timeout_hit) timeout_d = 1'b1;
            if (unlock_req || timeout_hit) begin
               // A frame arriving in the release cycle still counts as pending.
               state_d   = (pending || frame_edge) ? S_READY : S_IDLE;
               pending_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         valid_q      <= 1'b0;
         frame_count  <= 32'd0;
         ts_snap      <= 32'd0;
         drop_count   <= 8'd0;
         overrun_flag <= 1'b0;
         timeout_flag <= 1'b0;
         pending      <= 1'b0;
         tcnt         <= '0;
         being_read_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of statement order.
         state        <= state_d;
         valid_q      <= sfft_output_valid;
         if (frame_edge) frame_count <= frame_count + 32'd1;
         ts_snap      <= ts_d;
         drop_count   <= drop_d;
         overrun_flag <= overrun_d;
         timeout_flag <= timeout_d;
         pending      <= pending_d;
         tcnt         <= tcnt_d;
         // Registered from the next state so the flag tracks the FSM exactly.
         being_read_q <= (state_d == S_LOCKED);
      end
   end

   assign sfft_output_being_read = being_read_q;

   // -----------------------------------------------------------------------
   // Read path: cycle N address decode, N+1 BRAM data, N+2 readdata.
   // -----------------------------------------------------------------------
   logic [AW-1:0] addr_hold;
   logic          r1_valid;
   logic          r1_is_bin;
   logic          r1_bin_ok;
   logic [1:0]    r1_byte_sel;
   logic [7:0]    r1_reg_byte;

   // The BRAM address follows the bus during an accepted read and holds
   // its last value otherwise.
   assign sfft_read_addr = rd_accept ? address[AW+1:2] : addr_hold;

   always_comb begin
      reg_byte = 8'h00;
      if (!is_bin) begin
         unique case (ofs)
            16'd0:   reg_byte = ts_snap[7:0];
            16'd1:   reg_byte = ts_snap[15:8];
            16'd2:   reg_byte = ts_snap[23:16];
            16'd3:   reg_byte = ts_snap[31:24];
            16'd4:   reg_byte = status_byte;
            16'd5:   reg_byte = drop_count;
            default: reg_byte = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_hold     <= '0;
         r1_valid      <= 1'b0;
         r1_is_bin     <= 1'b0;
         r1_bin_ok     <= 1'b0;
         r1_byte_sel   <= 2'd0;
         r1_reg_byte   <= 8'h00;
         readdata      <= 8'h00;
         readdatavalid <= 1'b0;
      end else begin
         // Stage 1: capture the decoded request while the BRAM fetches.
         r1_valid <= rd_accept;
         if (rd_accept) begin
            addr_hold   <= address[AW+1:2];
            r1_is_bin   <= is_bin;
            r1_bin_ok   <= (state == S_LOCKED);
            r1_byte_sel <= address[1:0];
            r1_reg_byte <= reg_byte;
         end
         // Stage 2: select the byte and present it with its valid pulse.
         readdatavalid <= r1_valid;
         if (r1_valid) begin
            if (r1_is_bin)
               readdata <= r1_bin_ok ? sfft_read_data[8*r1_byte_sel +: 8] : 8'h00;
            else
               readdata <= r1_reg_byte;
         end
      end
   end

endmodule

// File: tb/tb_sfft_readout_controller.sv
// ---------------------------------------------------------------------------
// tb_sfft_readout_controller
//
// Directed bench for sfft_readout_controller with a short lock timeout.
// A small BRAM model answers sfft_read_addr one cycle later. Every lock
// session is kept shorter than the timeout except the one that tests it.
// ---------------------------------------------------------------------------
module tb_sfft_readout_controller;

   localparam int          BINS = 256;
   localparam int          TO   = 16;
   localparam logic [15:0] B    = 16'(BINS * 4);

   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect, write, read;
   logic [15:0] address;
   logic [7:0]  writedata;
   logic [7:0]  readdata;
   logic        readdatavalid;
   logic        sfft_output_valid;
   logic        sfft_read_error;
   logic [31:0] sfft_read_data;
   logic [7:0]  sfft_read_addr;
   logic        sfft_output_being_read;

   int tests = 0;
   int fails = 0;

   logic [31:0] bram [BINS];

   sfft_readout_controller #(
      .BINS           (BINS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .chipselect             (chipselect),
      .write                  (write),
      .read                   (read),
      .address                (address),
      .writedata              (writedata),
      .readdata               (readdata),
      .readdatavalid          (readdatavalid),
      .sfft_output_valid      (sfft_output_valid),
      .sfft_read_error        (sfft_read_error),
      .sfft_read_data         (sfft_read_data),
      .sfft_read_addr         (sfft_read_addr),
      .sfft_output_being_read (sfft_output_being_read)
   );

   always #5 clk = ~clk;

   // BRAM model: data one cycle after the address.
   always @(posedge clk) sfft_read_data <= bram[sfft_read_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   // Single read: expects readdatavalid exactly two edges after the request.
   task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
      int lat;
      lat = 0;
      @(posedge clk); #1;
      chipselect = 1'b1; read = 1'b1; address = a;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin chipselect = 1'b0; read = 1'b0; end
         if (readdatavalid) begin lat = k; break; end
      end
      check({tag, " latency"}, lat, 2);
      if (lat != 0) check({tag, " data"}, {24'd0, readdata}, {24'd0, exp});
   endtask

   // Four back-to-back reads from a0..a0+3; expects four consecutive pulses.
   task automatic bus_burst(input string tag, input logic [15:0] a0, input logic [31:0] exp_word);
      logic [7:0] got [4];
      int         cyc [4];
      int         n;
      n = 0;
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1;
         if (readdatavalid && n < 4) begin
            got[n] = readdata;
            cyc[n] = j;
            n++;
         end
         if (j < 4) begin
            chipselect = 1'b1; read = 1'b1; address = a0 + 16'(j);
         end else begin
            chipselect = 1'b0; read = 1'b0;
         end
      end
      check({tag, " pulses"}, n, 4);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_word[8*i +: 8]});
         check($sformatf("%s cycle%0d", tag, i), cyc[i], i + 2);
      end
   endtask

   task automatic frame_pulse();
      @(posedge clk); #1; sfft_output_valid = 1'b1;
      @(posedge clk); #1; sfft_output_valid = 1'b0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < BINS; i++) bram[i] = 32'h5A00_0000 | i;
      bram[5] = 32'hA1B2_C3D4;

      reset = 1'b1;
      chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = 16'd0; writedata = 8'd0;
      sfft_output_valid = 1'b0; sfft_read_error = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset readdata",      {24'd0, readdata}, 32'h0);
      check("reset readdatavalid", readdatavalid, 0);
      check("reset read_addr",     {24'd0, sfft_read_addr}, 32'h0);
      check("reset being_read",    sfft_output_being_read, 0);
      reset = 1'b0;

      // Session 1: frame, lock, status and timestamp burst.
      bus_read("status idle", B + 16'd4, 8'h00);
      frame_pulse();
      bus_read("status ready", B + 16'd4, 8'h01);
      bus_write(B, 8'h01);
      check("lock being_read", sfft_output_being_read, 1);
      bus_read("status locked", B + 16'd4, 8'h03);
      bus_burst("ts burst", B, 32'h0000_0001);
      bus_write(B, 8'h00);
      check("unlock being_read", sfft_output_being_read, 0);

      // Session 2: single byte reads of bin 5.
      frame_pulse();
      bus_write(B, 8'h01);
      bus_read("bin5 b0", 16'd20, 8'hD4);
      bus_read("bin5 b1", 16'd21, 8'hC3);
      bus_read("bin5 b2", 16'd22, 8'hB2);
      bus_read("bin5 b3", 16'd23, 8'hA1);
      bus_write(B, 8'h00);

      // Session 3: back-to-back bin reads, then a read error sets overrun.
      frame_pulse();
      bus_write(B, 8'h01);
      bus_burst("bin5 burst", 16'd20, 32'hA1B2_C3D4);
      @(posedge clk); #1; sfft_read_error = 1'b1;
      @(posedge clk); #1; sfft_read_error = 1'b0;
      bus_read("status rd_err", B + 16'd4, 8'h07);
      bus_write(B, 8'h00);
      bus_read("status idle overrun", B + 16'd4, 8'h04);

      // Session 4: three frames dropped while locked.
      frame_pulse();
      bus_write(B, 8'h01);
      frame_pulse();
      frame_pulse();
      frame_pulse();
      bus_read("drop_count 3", B + 16'd5, 8'h03);
      bus_read("status overrun", B + 16'd4, 8'h07);
      bus_write(B, 8'h00);
      bus_read("status pending", B + 16'd4, 8'h05);
      bus_write(B, 8'h02);
      bus_read("drop cleared", B + 16'd5, 8'h00);
      bus_read("status cleared", B + 16'd4, 8'h01);

      // Session 5: lock held until the timeout releases it.
      bus_write(B, 8'h01);
      check("to lock being_read", sfft_output_being_read, 1);
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (!sfft_output_being_read) begin n = k; break; end
      end
      check("timeout cycles", n, TO);
      bus_read("status timeout", B + 16'd4, 8'h08);

      // Session 6: IDLE behaviour and read/write collision.
      bus_read("bin idle", 16'd20, 8'h00);
      bus_write(B, 8'h01);
      check("idle lock ignored", sfft_output_being_read, 0);
      bus_read("status after idle lock", B + 16'd4, 8'h08);
      @(posedge clk); #1;
      chipselect = 1'b1; read = 1'b1; write = 1'b1; address = B + 16'd4; writedata = 8'h00;
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
      n = 0;
      for (int k = 0; k < 4; k++) begin
         if (readdatavalid) n++;
         @(posedge clk); #1;
      end
      check("rd+wr read dropped", n, 0);
      bus_write(B, 8'h02);
      bus_read("status clear timeout", B + 16'd4, 8'h00);

      // Session 7: reset during a lock.
      frame_pulse();
      bus_write(B, 8'h01);
      check("pre-reset being_read", sfft_output_being_read, 1);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check("async release", sfft_output_being_read, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      bus_read("status post reset", B + 16'd4, 8'h00);
      bus_read("ts post reset", B, 8'h00);
      frame_pulse();
      bus_write(B, 8'h01);
      bus_read("ts restart", B, 8'h01);
      bus_write(B, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/sfft_readout_controller.md
Name: sfft_readout_controller

Overview:
- Sequences host (bus-driver) access to one completed SFFT output frame: detects new frames, grants an exclusive read lock, and holds the pipeline's output buffer while the host reads it.
- Serves 8-bit byte reads of the 32-bit bins with a fixed latency, snapshots the frame timestamp, and reports overrun and timeout.
- Sits between the 8-bit memory-mapped bus slave and the SFFT pipeline's output BRAM port, replacing ad-hoc read glue in the top level.

Parameters:
- BINS, 256, number of 32-bit bins per frame (power of 2); bin address width is log2(BINS).
- TIMEOUT_CYCLES, 1000000, maximum number of clk cycles a lock may be held before it is forcibly released.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- chipselect  in  1  bus select.
- write  in  1  bus write strobe, qualified by chipselect.
- read  in  1  bus read strobe, qualified by chipselect.
- address  in  16  bus byte address.
- writedata  in  8  bus write data.
- readdata  out  8  registered read data.
- readdatavalid  out  1  one-cycle pulse; readdata is valid in this cycle.
- sfft_output_valid  in  1  level from pipeline; a rising edge marks a new frame.
- sfft_read_error  in  1  pipeline flag: the output buffer was disturbed during a read.
- sfft_read_data  in  32  BRAM data; valid 1 cycle after sfft_read_addr.
- sfft_read_addr  out  log2(BINS)  bin index presented to the BRAM.
- sfft_output_being_read  out  1  high while the lock is held; pipeline must not overwrite its output.

Behaviour:
- Everything is synchronous to clk. reset clears all state: FSM=IDLE, frame_count=0, ts_snap=0, drop_count=0, all sticky flags=0, pending=0, timeout counter=0. Outputs at reset: readdata=0, readdatavalid=0, sfft_read_addr=0, sfft_output_being_read=0.
- Reset asserted mid-lock releases the lock immediately (asynchronously).
- Frame detect: register sfft_output_valid; a rising edge increments frame_count (32-bit, wraps 0xFFFFFFFF->0).
- FSM states:
  - IDLE: no frame available.
  - READY: a frame is available and unlocked.
  - LOCKED: host holds the frame.
- IDLE->READY on a frame edge.
- READY->LOCKED on a control write with bit0=1. In the same edge: ts_snap<=frame_count and the timeout counter clears.
- A lock write in IDLE is ignored. This holds even if a frame edge arrives in the same cycle: that edge moves the FSM to READY only.
- A frame edge in READY keeps the FSM in READY (newest frame; not counted as dropped).
- LOCKED->(pending?READY:IDLE), pending<=0, on any of:
  - control write with bit0=0;
  - timeout counter reaching TIMEOUT_CYCLES-1; this also sets the timeout sticky flag.
- In LOCKED:
  - A frame edge sets pending, sets the overrun sticky flag, and increments drop_count (8-bit, saturates at 255).
  - sfft_read_error=1 in any cycle sets the overrun sticky flag.
- sfft_output_being_read = (state==LOCKED), registered.
- Register map (byte address A, base B = BINS*4):
  - A<B, read: bin A[log2(BINS)+1:2], byte A[1:0]; byte 0 = bits 7:0 (little-endian, no software swap needed). Returns 0 if not LOCKED.
  - B..B+3, read: ts_snap bytes, little-endian.
  - B+4, read: status = {4'b0, timeout, overrun, locked, state!=IDLE}.
  - B+5, read: drop_count.
  - B, write: control. bit0 = lock(1)/unlock(0). bit1=1 clears the overrun flag, timeout flag and drop_count.
  - Writes to any other address are ignored. Reads of any other address return 0.
- Read timing: a read accepted in cycle N drives sfft_read_addr combinationally from address in cycle N; the BRAM returns data in N+1; readdata and readdatavalid are registered in N+2. All addresses use the same 2-cycle latency.
- sfft_read_addr holds its last value when no read is in progress.
- Reads may issue back-to-back every cycle; each produces its own valid pulse in order.
- Read and write asserted in the same cycle: the write is performed and the read is dropped (no readdatavalid).
- Sticky-flag clear and a flag-set event in the same cycle: the set wins.
- Control writes: bit0 and bit1 act in the same cycle. An unlock (bit0=0) in READY or IDLE has no effect on state.

Test Plan:
- Reset, then one sfft_output_valid rise -> status(B+4) reads 0x01. Write B=0x01 -> sfft_output_being_read=1 next cycle; status=0x03; B..B+3 read 01,00,00,00.
- LOCKED with BRAM bin 5 = 0xA1B2C3D4 -> reads of addresses 20,21,22,23 return D4,C3,B2,A1, each with readdatavalid exactly 2 cycles after its read; back-to-back reads return 4 pulses in 4 consecutive cycles.
- Lock held, 3 frame edges -> B+5 reads 3, overrun=1. Unlock -> READY (status bit0=1). Write B=0x02 -> B+5=0, status=0x01.
- TIMEOUT_CYCLES=16, lock and hold -> being_read falls after 16 cycles; status=0x08 (timeout set, no frame pending -> IDLE).
- Bin read while IDLE -> returns 0x00 with readdatavalid. Lock write in IDLE -> ignored; being_read stays 0.
- Assert reset during LOCKED -> being_read=0 immediately; after release status=0x00, ts_snap=0, frame_count restarts (first frame then snapshots 1).
